// File: rtl/bellek_pkg.sv
// Shared widths, op-codes, state encoding and command legality rule for the
// XOR-keyed memory sequencer.
package bellek_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned SUM_W    = ADDR_W + 1;
  localparam int unsigned KEY_ADDR = 255;

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    FIN
  } state_t;

  // A burst must be non-empty and end at or below KEY_ADDR-1; the sum is one
  // bit wider than the address so a large start plus length cannot wrap.
  function automatic logic cmd_legal(input logic [1:0]        op,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] len);
    logic [SUM_W-1:0] span_end;
    logic             ok;
    span_end = SUM_W'(addr) + SUM_W'(len);
    case (op)
      OP_KEY:       ok = 1'b1;
      OP_WR, OP_RD: ok = (len != '0) && (span_end <= SUM_W'(KEY_ADDR));
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bellek_denetleyici_if.sv
// Command, stream and memory-pin bundle between the sequencer and its
// surroundings; slave is the sequencer side, master the command/stream side.
interface bellek_denetleyici_if;
  import bellek_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] key_in;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  logic [DATA_W-1:0] mem_d;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic              mem_ke;
  logic [DATA_W-1:0] mem_q;

  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, key_in,
    input  s_valid, s_data, m_ready, mem_q,
    output cmd_ready, s_ready, m_valid, m_data,
    output mem_d, mem_a, mem_we, mem_ke,
    output busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, key_in,
    output s_valid, s_data, m_ready, mem_q,
    input  cmd_ready, s_ready, m_valid, m_data,
    input  mem_d, mem_a, mem_we, mem_ke,
    input  busy, done, err
  );

endinterface

// File: rtl/bellek_denetleyici.sv
// Command sequencer owning the pins of the XOR-keyed 256x32 memory: key load,
// write bursts from the s-stream and read bursts onto the m-stream.
module bellek_denetleyici
  import bellek_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  bellek_denetleyici_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] d_r;
  logic [DATA_W-1:0] m_data_r;
  logic              cmd_ready_r;
  logic              m_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              accept;
  logic              last_word;

  assign accept    = (state == IDLE) && cmd_ready_r && bus.cmd_valid;
  assign last_word = (remaining == ADDR_W'(1));

  // Sequencer: state, burst counters and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_r      <= '0;
      remaining   <= '0;
      d_r         <= '0;
      m_data_r    <= '0;
      cmd_ready_r <= 1'b0;
      m_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (!cmd_legal(bus.cmd_op, bus.cmd_addr, bus.cmd_len)) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
              state  <= FIN;
            end else begin
              case (bus.cmd_op)
                OP_KEY: begin
                  d_r   <= bus.key_in;
                  state <= KEY;
                end
                OP_WR: begin
                  addr_r    <= bus.cmd_addr;
                  remaining <= bus.cmd_len;
                  state     <= WR;
                end
                default: begin
                  addr_r    <= bus.cmd_addr;
                  remaining <= bus.cmd_len;
                  state     <= RD_ISSUE;
                end
              endcase
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        KEY: begin
          done_r <= 1'b1;
          state  <= FIN;
        end
        WR: begin
          if (bus.s_valid) begin
            d_r <= bus.s_data;
            if (last_word) begin
              done_r <= 1'b1;
              state  <= FIN;
            end else begin
              addr_r    <= addr_r + ADDR_W'(1);
              remaining <= remaining - ADDR_W'(1);
            end
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          m_data_r  <= bus.mem_q;
          m_valid_r <= 1'b1;
          state     <= RD_OUT;
        end
        RD_OUT: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            if (last_word) begin
              done_r <= 1'b1;
              state  <= FIN;
            end else begin
              addr_r    <= addr_r + ADDR_W'(1);
              remaining <= remaining - ADDR_W'(1);
              state     <= RD_ISSUE;
            end
          end
        end
        FIN: begin
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe and key strobe follow the state directly; both are forced
  // low while reset is asserted so an aborted burst cannot write once more.
  assign bus.mem_we    = (state == WR) && bus.s_valid && !rst;
  assign bus.mem_ke    = (state == KEY) && !rst;
  assign bus.mem_a     = addr_r;
  assign bus.mem_d     = (state == WR) ? bus.s_data : d_r;
  assign bus.s_ready   = (state == WR) && !rst;

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_data    = m_data_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule
